// File: rtl/muldiv_pkg.sv
// ============================================================================
//  Module   : muldiv_pkg
//  Brief    : Shared types, constants and op-decode helpers for muldiv_unit
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_pkg;

  // funct3 encoding of the RV32M ops
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_CALC = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

  function automatic logic is_div(op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_rem(op_e op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  // MUL yields the same low word either way; treat it as signed
  function automatic logic is_signed_a(op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_if.sv
// ============================================================================
//  Module   : muldiv_if
//  Brief    : Issue and write-back handshake bundle of the mul/div unit
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface muldiv_if #(
  parameter int XLEN = 32
);
  import muldiv_pkg::*;

  logic            in_valid;
  logic            in_ready;
  op_e             in_op;
  logic [4:0]      in_rd;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic            out_valid;
  logic            out_ready;
  logic [4:0]      out_rd;
  logic            out_wen;
  logic [XLEN-1:0] out_wdata;

  // Decode / write-back side
  modport master (
    output in_valid, in_op, in_rd, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_rd, out_wen, out_wdata
  );

  // Execution unit side
  modport slave (
    input  in_valid, in_op, in_rd, in_a, in_b, out_ready,
    output in_ready, out_valid, out_rd, out_wen, out_wdata
  );

endinterface

`default_nettype wire

// File: rtl/muldiv_step.sv
// ============================================================================
//  Module   : muldiv_step
//  Brief    : One radix-2 iteration on the 64-bit accumulator.
//             Multiply: {hi,lo} with multiplier in lo; conditional add of the
//             multiplicand into hi, then shift right by one.
//             Divide  : {rem,quot} restoring step; shift left, trial subtract,
//             keep the difference when it does not borrow.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_step #(
  parameter int XLEN = 32
) (
  input  wire              i_is_div,
  input  wire [XLEN-1:0]   i_opnd,
  input  wire [2*XLEN-1:0] i_acc,
  output logic [2*XLEN-1:0] o_acc
);

  logic [XLEN-1:0] w_hi;
  logic [XLEN-1:0] w_lo;
  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_part;
  logic            w_ge;
  logic [XLEN-1:0] w_rem_next;

  assign w_hi = i_acc[2*XLEN-1:XLEN];
  assign w_lo = i_acc[XLEN-1:0];

  // Multiply: carry out of the add becomes the new MSB after the shift
  assign w_sum = {1'b0, w_hi} + (w_lo[0] ? {1'b0, i_opnd} : {(XLEN+1){1'b0}});

  // Divide: partial remainder shifted left with the next dividend bit
  assign w_part     = i_acc[2*XLEN-1:XLEN-1];
  assign w_ge       = (w_part >= {1'b0, i_opnd});
  // When w_ge holds the true difference is below the divisor, so XLEN bits suffice
  assign w_rem_next = w_ge ? (w_part[XLEN-1:0] - i_opnd) : w_part[XLEN-1:0];

  // Select the step flavour for the current op
  always_comb begin
    o_acc = {w_sum, w_lo[XLEN-1:1]};
    if (i_is_div) begin
      o_acc = {w_rem_next, w_lo[XLEN-2:0], w_ge};
    end
  end

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
//  Module   : muldiv_unit
//  Brief    : Iterative RV32M multiply/divide unit with valid/ready issue and
//             write-back. FSM IDLE -> PREP -> CALC -> DONE -> IDLE.
//             Optional macro MULDIV_FAST_MUL_EN: multiplies complete in one
//             cycle on a 33x33 signed multiplier (IDLE -> DONE).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  wire        clk,
  input  wire        reset,
  input  wire        flush,
  muldiv_if.slave    bus,
  output logic       busy
);

  localparam int ITERS = XLEN / STEPS_PER_CYCLE;
  localparam int CNT_W = $clog2(ITERS) + 1;

  state_e                r_state;
  state_e                w_next;
  op_e                   r_op;
  logic [4:0]            r_rd;
  logic [XLEN-1:0]       r_a;
  logic [XLEN-1:0]       r_b;
  logic [XLEN-1:0]       r_opnd;
  logic [XLEN-1:0]       r_wdata;
  logic [2*XLEN-1:0]     r_acc;
  logic                  r_neg_q;
  logic                  r_neg_r;
  logic [CNT_W-1:0]      r_cnt;

  logic                  w_accept;
  logic                  w_is_div;
  logic                  w_a_neg;
  logic                  w_b_neg;
  logic [XLEN-1:0]       w_abs_a;
  logic [XLEN-1:0]       w_abs_b;
  logic                  w_div_zero;
  logic                  w_ovf;
  logic                  w_special;
  logic [XLEN-1:0]       w_special_res;
  logic                  w_last;
  logic [2*XLEN-1:0]     w_step_acc;
  logic [2*XLEN-1:0]     w_fix64;
  logic [XLEN-1:0]       w_quot;
  logic [XLEN-1:0]       w_rem;
  logic [XLEN-1:0]       w_final;
  logic [2*XLEN-1:0]     w_chain [STEPS_PER_CYCLE+1];

  // Handshake and status outputs
  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.out_rd    = r_rd;
  assign bus.out_wen   = (r_state == S_DONE) && (r_rd != 5'd0);
  assign bus.out_wdata = r_wdata;
  assign busy          = (r_state != S_IDLE);

  // A flush in IDLE blocks acceptance of a simultaneously presented op
  assign w_accept = bus.in_valid && (r_state == S_IDLE) && !flush;

  // Operand conditioning, evaluated while in PREP
  assign w_is_div   = is_div(r_op);
  assign w_a_neg    = is_signed_a(r_op) && r_a[XLEN-1];
  assign w_b_neg    = is_signed_b(r_op) && r_b[XLEN-1];
  assign w_abs_a    = w_a_neg ? -r_a : r_a;
  assign w_abs_b    = w_b_neg ? -r_b : r_b;
  assign w_div_zero = w_is_div && (r_b == '0);
  assign w_ovf      = ((r_op == OP_DIV) || (r_op == OP_REM)) &&
                      (r_a == INT_MIN) && (r_b == '1);
  assign w_special  = w_div_zero || w_ovf;

  // Architectural results for divide-by-zero and signed overflow
  always_comb begin
    w_special_res = '0;
    if (w_div_zero) begin
      w_special_res = is_rem(r_op) ? r_a : DIV0_QUOT;
    end else if (w_ovf) begin
      w_special_res = (r_op == OP_DIV) ? INT_MIN : '0;
    end
  end

  // Chain of radix-2 steps evaluated each CALC cycle
  assign w_chain[0] = r_acc;
  generate
    for (genvar gi = 0; gi < STEPS_PER_CYCLE; gi++) begin : g_step
      muldiv_step #(.XLEN(XLEN)) u_step (
        .i_is_div (w_is_div),
        .i_opnd   (r_opnd),
        .i_acc    (w_chain[gi]),
        .o_acc    (w_chain[gi+1])
      );
    end
  endgenerate
  assign w_step_acc = w_chain[STEPS_PER_CYCLE];

  assign w_last  = (r_cnt == CNT_W'(ITERS - 1));
  assign w_fix64 = r_neg_q ? -w_step_acc : w_step_acc;
  assign w_quot  = r_neg_q ? -w_step_acc[XLEN-1:0] : w_step_acc[XLEN-1:0];
  assign w_rem   = r_neg_r ? -w_step_acc[2*XLEN-1:XLEN] : w_step_acc[2*XLEN-1:XLEN];

  // Pick the result word and apply the sign fixup
  always_comb begin
    w_final = w_fix64[XLEN-1:0];
    case (r_op)
      OP_MUL:                      w_final = w_fix64[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_fix64[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             w_final = w_quot;
      OP_REM, OP_REMU:             w_final = w_rem;
      default:                     w_final = w_fix64[XLEN-1:0];
    endcase
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     w_fa;
  logic signed [XLEN:0]     w_fb;
  logic signed [2*XLEN+1:0] w_fprod;
  logic [XLEN-1:0]          w_fres;

  assign w_fa    = {is_signed_a(bus.in_op) && bus.in_a[XLEN-1], bus.in_a};
  assign w_fb    = {is_signed_b(bus.in_op) && bus.in_b[XLEN-1], bus.in_b};
  assign w_fprod = w_fa * w_fb;
  assign w_fres  = (bus.in_op == OP_MUL) ? w_fprod[XLEN-1:0] : w_fprod[2*XLEN-1:XLEN];
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; flush overrides every other transition
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
`ifdef MULDIV_FAST_MUL_EN
          w_next = is_div(bus.in_op) ? S_PREP : S_DONE;
`else
          w_next = S_PREP;
`endif
        end
      end
      S_PREP:  w_next = w_special ? S_DONE : S_CALC;
      S_CALC:  w_next = w_last ? S_DONE : S_CALC;
      S_DONE:  w_next = bus.out_ready ? S_IDLE : S_DONE;
      default: w_next = S_IDLE;
    endcase
    if (flush) begin
      w_next = S_IDLE;
    end
  end

  // Operand latch, iteration datapath and result register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op    <= OP_MUL;
      r_rd    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_opnd  <= '0;
      r_wdata <= '0;
      r_acc   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_cnt   <= '0;
    end else if (!flush) begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op <= bus.in_op;
            r_rd <= bus.in_rd;
            r_a  <= bus.in_a;
            r_b  <= bus.in_b;
`ifdef MULDIV_FAST_MUL_EN
            if (!is_div(bus.in_op)) begin
              r_wdata <= w_fres;
            end
`endif
          end
        end
        S_PREP: begin
          // Multiplier (mul) or dividend (div) starts in the low half
          r_acc   <= {{XLEN{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
          r_opnd  <= w_is_div ? w_abs_b : w_abs_a;
          r_neg_q <= w_a_neg ^ w_b_neg;
          r_neg_r <= w_a_neg;
          r_cnt   <= '0;
          if (w_special) begin
            r_wdata <= w_special_res;
          end
        end
        S_CALC: begin
          r_acc <= w_step_acc;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_wdata <= w_final;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
